// File: rtl/pic_host_sequencer_if.sv
// PIC-side pin bundle for pic_host_sequencer: chip select, strobes, A0, data bus and INT.
// The sequencer drives through the master modport; the PIC (or a model of it) uses slave.
interface pic_host_sequencer_if;
  logic       chip_select_n;
  logic       write_enable_n;
  logic       read_enable_n;
  logic       interrupt_acknowledge_n;
  logic       address;
  logic [7:0] data_bus_out;
  logic       data_bus_io_enable;
  logic [7:0] data_bus_in;
  logic       interrupt_to_cpu;

  modport master (
    output chip_select_n, write_enable_n, read_enable_n, interrupt_acknowledge_n,
    output address, data_bus_out, data_bus_io_enable,
    input  data_bus_in, interrupt_to_cpu
  );

  modport slave (
    input  chip_select_n, write_enable_n, read_enable_n, interrupt_acknowledge_n,
    input  address, data_bus_out, data_bus_io_enable,
    output data_bus_in, interrupt_to_cpu
  );
endinterface

// File: rtl/pic_host_sequencer.sv
// 8259 host-side bus sequencer: ICW init, OCW writes, status reads and INTA vector capture.
// Optional macro PIC_HOST_MCS80_EN enables the three-pulse MCS-80 INTA sequence.
module pic_host_sequencer #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 init_start,
  input  logic [7:0]           icw1,
  input  logic [7:0]           icw2,
  input  logic [7:0]           icw3,
  input  logic [7:0]           icw4,
  input  logic                 cmd_req,
  output logic                 cmd_ack,
  input  logic                 cmd_a0,
  input  logic [7:0]           cmd_data,
  input  logic                 rd_req,
  output logic                 rd_valid,
  input  logic                 rd_a0,
  output logic [7:0]           rd_data,
  input  logic                 int_enable,
  input  logic                 mcs80_mode,
  pic_host_sequencer_if.master pic,
  output logic [7:0]           vector,
  output logic [7:0]           call_opcode,
  output logic                 vector_valid,
  output logic                 busy,
  output logic                 init_done
);

  // state  | meaning
  // IDLE   | bus quiet; arbitrate init > INTA > cmd write > read
  // SETUP  | CS_n low, A0 and write data presented
  // STROBE | WR_n, RD_n or INTA_n low for STROBE_CYCLES
  // HOLD   | strobe released, CS_n and data still held
  // GAP    | all strobes high for GAP_CYCLES; then next word/pulse or IDLE
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;
  typedef enum logic [1:0] {OP_INIT, OP_CMD, OP_RD, OP_INTA} op_t;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD    = 4'(GAP_CYCLES - 1);

  state_t          state_q, state_n;
  op_t             op_q, op_n;
  logic [3:0]      cnt_q, cnt_n;
  logic [1:0]      word_q, word_n;
  logic [1:0]      pulse_q, pulse_n;
  logic [1:0]      last_pulse_q;
  logic [1:0]      inta_last;

  logic            addr_q;
  logic [7:0]      data_q;
  logic [3:0][7:0] icw_q;
  logic [3:0][7:0] pend_icw_q;
  logic [3:0][7:0] icw_in;
  logic [3:0][7:0] icw_src;
  logic            pend_q;
  logic            block_q;
  logic [7:0]      rd_data_q;
  logic [7:0]      vector_q;

  logic            grant_init, grant_inta, grant_cmd, grant_rd;
  logic            init_req, int_ok;
  logic            gap_end, strobe_end, inta_final;
  logic [1:0]      next_word;
  logic            next_word_ok;
  logic            is_write, on_bus;

  assign icw_in     = {icw4, icw3, icw2, icw1};
  assign icw_src    = init_start ? icw_in : pend_icw_q;
  assign init_req   = init_start | pend_q;
  assign int_ok     = pic.interrupt_to_cpu & int_enable & ~block_q;
  assign gap_end    = (state_q == S_GAP) && (cnt_q == 4'd0);
  assign strobe_end = (state_q == S_STROBE) && (cnt_q == 4'd0);
  assign inta_final = (op_q == OP_INTA) && (pulse_q == last_pulse_q);

`ifdef PIC_HOST_MCS80_EN
  logic [7:0] call_q;

  assign inta_last = mcs80_mode ? 2'd2 : 2'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      call_q <= 8'h00;
    end else if (strobe_end && op_q == OP_INTA && pulse_q == 2'd0 && last_pulse_q == 2'd2) begin
      call_q <= pic.data_bus_in;
    end
  end

  assign call_opcode = call_q;
`else
  logic unused_mcs80;

  assign unused_mcs80 = mcs80_mode;
  assign inta_last    = 2'd1;
  assign call_opcode  = 8'h00;
`endif

  // ICW3 only in cascade mode (SNGL=0), ICW4 only when IC4=1.
  always_comb begin
    next_word    = 2'd0;
    next_word_ok = 1'b0;
    case (word_q)
      2'd0: begin
        next_word    = 2'd1;
        next_word_ok = 1'b1;
      end
      2'd1: begin
        if (!icw_q[0][1]) begin
          next_word    = 2'd2;
          next_word_ok = 1'b1;
        end else if (icw_q[0][0]) begin
          next_word    = 2'd3;
          next_word_ok = 1'b1;
        end
      end
      2'd2: begin
        if (icw_q[0][0]) begin
          next_word    = 2'd3;
          next_word_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_CMD;
      cnt_q   <= 4'd0;
      word_q  <= 2'd0;
      pulse_q <= 2'd0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      cnt_q   <= cnt_n;
      word_q  <= word_n;
      pulse_q <= pulse_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    op_n       = op_q;
    cnt_n      = cnt_q;
    word_n     = word_q;
    pulse_n    = pulse_q;
    grant_init = 1'b0;
    grant_inta = 1'b0;
    grant_cmd  = 1'b0;
    grant_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init_req) begin
          state_n    = S_SETUP;
          op_n       = OP_INIT;
          word_n     = 2'd0;
          grant_init = 1'b1;
        end else if (int_ok) begin
          state_n    = S_STROBE;
          op_n       = OP_INTA;
          cnt_n      = STROBE_LOAD;
          pulse_n    = 2'd0;
          grant_inta = 1'b1;
        end else if (cmd_req) begin
          state_n    = S_SETUP;
          op_n       = OP_CMD;
          grant_cmd  = 1'b1;
        end else if (rd_req) begin
          state_n    = S_SETUP;
          op_n       = OP_RD;
          grant_rd   = 1'b1;
        end
      end
      S_SETUP: begin
        state_n = S_STROBE;
        cnt_n   = STROBE_LOAD;
      end
      S_STROBE: begin
        if (cnt_q != 4'd0) begin
          cnt_n = cnt_q - 4'd1;
        end else if (op_q == OP_INTA) begin
          state_n = S_GAP;
          cnt_n   = GAP_LOAD;
        end else begin
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        state_n = S_GAP;
        cnt_n   = GAP_LOAD;
      end
      S_GAP: begin
        if (cnt_q != 4'd0) begin
          cnt_n = cnt_q - 4'd1;
        end else if (op_q == OP_INIT && next_word_ok) begin
          state_n = S_SETUP;
          word_n  = next_word;
        end else if (op_q == OP_INTA && !inta_final) begin
          state_n = S_STROBE;
          cnt_n   = STROBE_LOAD;
          pulse_n = pulse_q + 2'd1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= 1'b0;
      data_q       <= 8'h00;
      icw_q        <= '0;
      pend_icw_q   <= '0;
      pend_q       <= 1'b0;
      block_q      <= 1'b0;
      last_pulse_q <= 2'd1;
      rd_data_q    <= 8'h00;
      vector_q     <= 8'h00;
    end else begin
      if (grant_init) begin
        icw_q  <= icw_src;
        addr_q <= 1'b0;
        data_q <= icw_src[0] | 8'h10;
      end else if (grant_inta) begin
        addr_q       <= 1'b0;
        last_pulse_q <= inta_last;
      end else if (grant_cmd) begin
        addr_q <= cmd_a0;
        data_q <= cmd_data;
      end else if (grant_rd) begin
        addr_q <= rd_a0;
      end else if (gap_end && op_q == OP_INIT && next_word_ok) begin
        addr_q <= 1'b1;
        data_q <= icw_q[next_word];
      end

      // A start that arrives while busy is parked and replayed from IDLE.
      if (grant_init) begin
        pend_q <= 1'b0;
      end else if (init_start) begin
        pend_q     <= 1'b1;
        pend_icw_q <= icw_in;
      end

      if (gap_end && inta_final) begin
        block_q <= 1'b1;
      end else if (state_q == S_IDLE) begin
        block_q <= 1'b0;
      end

      if (strobe_end && op_q == OP_RD) begin
        rd_data_q <= pic.data_bus_in;
      end
      if (strobe_end && op_q == OP_INTA && pulse_q == 2'd1) begin
        vector_q <= pic.data_bus_in;
      end
    end
  end

  // Strobes decode straight from the state register so an async reset releases them at once.
  assign is_write = (op_q == OP_INIT) || (op_q == OP_CMD);
  assign on_bus   = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);

  assign pic.chip_select_n           = ~(on_bus && op_q != OP_INTA);
  assign pic.write_enable_n          = ~(state_q == S_STROBE && is_write);
  assign pic.read_enable_n           = ~(state_q == S_STROBE && op_q == OP_RD);
  assign pic.interrupt_acknowledge_n = ~(state_q == S_STROBE && op_q == OP_INTA);
  assign pic.address                 = addr_q;
  assign pic.data_bus_out            = data_q;
  assign pic.data_bus_io_enable      = on_bus && is_write;

  assign busy         = (state_q != S_IDLE);
  assign init_done    = gap_end && (op_q == OP_INIT) && !next_word_ok;
  assign cmd_ack      = gap_end && (op_q == OP_CMD);
  assign rd_valid     = gap_end && (op_q == OP_RD);
  assign vector_valid = gap_end && inta_final;
  assign rd_data      = rd_data_q;
  assign vector       = vector_q;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Self-checking bench for pic_host_sequencer: bus monitor plus PIC byte model and a
// transaction-level reference for init word lists, INTA byte selection and latencies.
`timescale 1ns/1ps
module tb_pic_host_sequencer;
  localparam int SC        = 2;
  localparam int GC        = 1;
  localparam int WR_CYC    = SC + 2 + GC;
  localparam int PULSE_CYC = SC + GC;
  localparam int EV_DONE   = 0;
  localparam int EV_ACK    = 1;
  localparam int EV_RDV    = 2;
  localparam int EV_VV     = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       init_start;
  logic [7:0] icw1, icw2, icw3, icw4;
  logic       cmd_req, cmd_a0, rd_req, rd_a0;
  logic [7:0] cmd_data;
  logic       cmd_ack, rd_valid, vector_valid, busy, init_done;
  logic [7:0] rd_data, vector, call_opcode;
  logic       int_enable, mcs80_mode;

  pic_host_sequencer_if bus();

  pic_host_sequencer #(.STROBE_CYCLES(SC), .GAP_CYCLES(GC)) dut (
    .clock(clock), .reset_n(reset_n), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_a0(rd_a0), .rd_data(rd_data),
    .int_enable(int_enable), .mcs80_mode(mcs80_mode), .pic(bus),
    .vector(vector), .call_opcode(call_opcode), .vector_valid(vector_valid),
    .busy(busy), .init_done(init_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle.
  logic [8:0] wr_q[$];
  logic [8:0] exp_q[$];
  int         ev_cnt[4] = '{default: 0};
  int         ev_t[4]   = '{default: 0};
  int         inta_pulses = 0;
  int         rd_strobes = 0;
  int         viol = 0;
  logic       rd_addr_seen = 1'b0;
  logic       prev_we = 1'b1, prev_re = 1'b1, prev_inta = 1'b1;

  always @(negedge clock) begin
    automatic int v = 0;
    prev_we   <= bus.write_enable_n;
    prev_re   <= bus.read_enable_n;
    prev_inta <= bus.interrupt_acknowledge_n;
    if (!bus.write_enable_n && prev_we) begin
      wr_q.push_back({bus.address, bus.data_bus_out});
      if (bus.chip_select_n || !bus.data_bus_io_enable) v++;
    end
    if (!bus.read_enable_n && prev_re) begin
      rd_strobes   <= rd_strobes + 1;
      rd_addr_seen <= bus.address;
      if (bus.chip_select_n || bus.data_bus_io_enable) v++;
    end
    if (!bus.interrupt_acknowledge_n) begin
      if (prev_inta) inta_pulses <= inta_pulses + 1;
      if (!bus.chip_select_n || bus.data_bus_io_enable) v++;
    end
    viol <= viol + v;
    if (init_done)    begin ev_cnt[EV_DONE] <= ev_cnt[EV_DONE] + 1; ev_t[EV_DONE] <= cyc; end
    if (cmd_ack)      begin ev_cnt[EV_ACK]  <= ev_cnt[EV_ACK] + 1;  ev_t[EV_ACK]  <= cyc; end
    if (rd_valid)     begin ev_cnt[EV_RDV]  <= ev_cnt[EV_RDV] + 1;  ev_t[EV_RDV]  <= cyc; end
    if (vector_valid) begin ev_cnt[EV_VV]   <= ev_cnt[EV_VV] + 1;   ev_t[EV_VV]   <= cyc; end
  end

  // PIC data-bus model: INTA pulse k returns byte k, otherwise the status byte.
  logic [7:0] inta_bytes[3];
  int         inta_base = 0;
  logic [7:0] rd_byte = 8'h00;
  int         bidx;
  always_comb begin
    bidx = inta_pulses - inta_base - 1;
    if (bidx < 0) bidx = 0;
    if (bidx > 2) bidx = 2;
    bus.data_bus_in = bus.interrupt_acknowledge_n ? rd_byte : inta_bytes[bidx[1:0]];
  end

  logic [7:0] exp_call = 8'h00;

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ev(input int kind, input int base, input string tag);
    int n = 0;
    while (ev_cnt[kind] == base && n < 300) begin
      tick();
      n++;
    end
    checks++;
    assert (ev_cnt[kind] != base) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected>%0d", tag, ev_cnt[kind], base);
    end
  endtask

  // Reference: the words an 8259 init sequence must put on the bus.
  task automatic push_init_words(input logic [7:0] i1, i2, i3, i4);
    exp_q.push_back({1'b0, i1 | 8'h10});
    exp_q.push_back({1'b1, i2});
    if (!i1[1]) exp_q.push_back({1'b1, i3});
    if (i1[0])  exp_q.push_back({1'b1, i4});
  endtask

  task automatic cmp_writes(input string tag, input int wbase);
    chk({tag, "_nwr"}, wr_q.size() - wbase, exp_q.size());
    for (int i = 0; i < exp_q.size() && wbase + i < wr_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wr_q[wbase + i], exp_q[i]);
  endtask

  task automatic run_init(input logic [7:0] i1, i2, i3, i4, input string tag);
    int base, wbase, t0;
    exp_q = {};
    push_init_words(i1, i2, i3, i4);
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    base = ev_cnt[EV_DONE];
    wbase = wr_q.size();
    t0 = cyc;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    wait_ev(EV_DONE, base, tag);
    repeat (4) tick();
    chk({tag, "_lat"}, ev_t[EV_DONE] - t0, exp_q.size() * WR_CYC);
    chk({tag, "_ndone"}, ev_cnt[EV_DONE] - base, 1);
    cmp_writes(tag, wbase);
  endtask

  task automatic run_inta(input logic mcs, input logic [7:0] b0, b1, b2, input string tag);
    int base, pbase, t0, n;
    inta_bytes[0] = b0; inta_bytes[1] = b1; inta_bytes[2] = b2;
    n = 2;
`ifdef PIC_HOST_MCS80_EN
    if (mcs) begin
      n = 3;
      exp_call = b0;
    end
`endif
    mcs80_mode = mcs;
    int_enable = 1'b1;
    pbase = inta_pulses;
    inta_base = inta_pulses;
    base = ev_cnt[EV_VV];
    t0 = cyc;
    bus.interrupt_to_cpu = 1'b1;
    wait_ev(EV_VV, base, tag);
    bus.interrupt_to_cpu = 1'b0;
    repeat (5) tick();
    chk({tag, "_lat"}, ev_t[EV_VV] - t0, n * PULSE_CYC);
    chk({tag, "_pulses"}, inta_pulses - pbase, n);
    chk({tag, "_nvalid"}, ev_cnt[EV_VV] - base, 1);
    chk({tag, "_vector"}, vector, b1);
    chk({tag, "_call"}, call_opcode, exp_call);
  endtask

  task automatic run_cmd_rd(input logic a0, input logic [7:0] d, input logic ra0,
                            input logic [7:0] rb, input string tag);
    int abase, rbase, wbase, sbase, t0;
    cmd_a0 = a0; cmd_data = d; rd_a0 = ra0; rd_byte = rb;
    abase = ev_cnt[EV_ACK];
    rbase = ev_cnt[EV_RDV];
    wbase = wr_q.size();
    sbase = rd_strobes;
    t0 = cyc;
    cmd_req = 1'b1;
    rd_req = 1'b1;
    wait_ev(EV_ACK, abase, {tag, "_ack"});
    cmd_req = 1'b0;
    wait_ev(EV_RDV, rbase, {tag, "_rdv"});
    rd_req = 1'b0;
    repeat (3) tick();
    exp_q = {};
    exp_q.push_back({a0, d});
    chk({tag, "_ack_lat"}, ev_t[EV_ACK] - t0, WR_CYC);
    chk({tag, "_rd_lat"}, ev_t[EV_RDV] - t0, 2 * WR_CYC + 1);
    cmp_writes(tag, wbase);
    chk({tag, "_nrd"}, rd_strobes - sbase, 1);
    chk({tag, "_rd_a0"}, rd_addr_seen, ra0);
    chk({tag, "_rd_data"}, rd_data, rb);
  endtask

  initial begin
    int base, wbase, n;
    reset_n = 1'b0;
    init_start = 1'b0;
    icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00;
    cmd_req = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
    rd_req = 1'b0; rd_a0 = 1'b0;
    int_enable = 1'b0; mcs80_mode = 1'b0;
    bus.interrupt_to_cpu = 1'b0;
    inta_bytes[0] = 8'h00; inta_bytes[1] = 8'h00; inta_bytes[2] = 8'h00;
    #3;
    chk("rst_cs_n", bus.chip_select_n, 1);
    chk("rst_strobes", {bus.write_enable_n, bus.read_enable_n, bus.interrupt_acknowledge_n}, 3'b111);
    chk("rst_addr", bus.address, 0);
    chk("rst_dout", bus.data_bus_out, 8'h00);
    chk("rst_ioen", bus.data_bus_io_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {init_done, cmd_ack, rd_valid, vector_valid}, 4'b0000);
    chk("rst_bytes", {vector, call_opcode, rd_data}, 24'h0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", busy, 0);

    run_init(8'h11, 8'h20, 8'h04, 8'h01, "init4");
    run_init(8'h12, 8'h28, 8'h04, 8'h01, "init_single");
    for (int i = 0; i < 6; i++)
      run_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), $sformatf("init_rnd%0d", i));

    run_inta(1'b0, 8'hCD, 8'h08, 8'h00, "inta8086");
`ifdef PIC_HOST_MCS80_EN
    run_inta(1'b1, 8'hCD, 8'h44, 8'h00, "inta_mcs80");
`else
    run_inta(1'b1, 8'hCD, 8'h44, 8'h00, "inta_mcs_ignored");
`endif
    for (int i = 0; i < 4; i++)
      run_inta(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
               $sformatf("inta_rnd%0d", i));

    // INT held with int_enable low must never start INTA.
    base = inta_pulses;
    int_enable = 1'b0;
    bus.interrupt_to_cpu = 1'b1;
    repeat (20) tick();
    chk("inta_disabled", inta_pulses - base, 0);
    bus.interrupt_to_cpu = 1'b0;
    tick();

    run_cmd_rd(1'b1, 8'hFB, 1'b0, 8'h5A, "cmd_rd");
    for (int i = 0; i < 4; i++)
      run_cmd_rd(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 8'($urandom), $sformatf("cmd_rd_rnd%0d", i));

    // init_start during a busy write is parked and runs after the write.
    wbase = wr_q.size();
    base = ev_cnt[EV_DONE];
    cmd_a0 = 1'b0; cmd_data = 8'h55;
    n = ev_cnt[EV_ACK];
    cmd_req = 1'b1;
    repeat (2) tick();
    icw1 = 8'h13; icw2 = 8'h40; icw3 = 8'h99; icw4 = 8'h03;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    wait_ev(EV_ACK, n, "pend_ack");
    cmd_req = 1'b0;
    wait_ev(EV_DONE, base, "pend_done");
    repeat (3) tick();
    exp_q = {};
    exp_q.push_back({1'b0, 8'h55});
    push_init_words(8'h13, 8'h40, 8'h99, 8'h03);
    cmp_writes("pend_init", wbase);

    // Reset during the ICW2 strobe.
    wbase = wr_q.size();
    base = ev_cnt[EV_DONE];
    icw1 = 8'h11; icw2 = 8'h20; icw3 = 8'h04; icw4 = 8'h01;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    n = 0;
    while (wr_q.size() < wbase + 2 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_mid_reach", wr_q.size() - wbase, 2);
    chk("rst_mid_we_low", bus.write_enable_n, 0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_we", bus.write_enable_n, 1);
    chk("rst_mid_cs", bus.chip_select_n, 1);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_nwr", wr_q.size() - wbase, 2);
    chk("rst_mid_ndone", ev_cnt[EV_DONE] - base, 0);

    chk("bus_protocol_viol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_host_sequencer.md
# pic_host_sequencer

CPU-side bus initiator for the 8259 PIC core. It drives the PIC's chip-select, read and write strobes, A0 and the data bus to issue initialisation words (ICW1–ICW4), operation command words (OCW1–OCW3) and status reads (IRR/ISR/mask). When the PIC raises its interrupt request it generates the INTA pulse train and captures the vector byte(s). It sits between a simple request/acknowledge host port and the PIC's external pins.

## Interface
- STROBE_CYCLES, 2: low time of every RD/WR/INTA strobe, in clocks (1..15)
- GAP_CYCLES, 1: high time between consecutive INTA pulses and after every bus cycle (1..15)
- clock  in  1  single system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- init_start  in  1  one-cycle pulse; latch icw1..icw4 and run the init sequence
- icw1, icw2, icw3, icw4  in  8 each  init words, sampled on init_start
- cmd_req / cmd_ack  in / out  1 / 1  OCW write request (level) / one-cycle grant at end of write
- cmd_a0, cmd_data  in  1, 8  A0 and byte for the OCW write
- rd_req / rd_valid  in / out  1 / 1  register read request (level) / one-cycle result strobe
- rd_a0  in  1  A0 for the read
- rd_data  out  8  captured read byte, held until the next read
- int_enable  in  1  permits automatic INTA sequences
- mcs80_mode  in  1  1 = three INTA pulses, 0 = two (8086)
- interrupt_to_cpu  in  1  PIC INT output
- chip_select_n, write_enable_n, read_enable_n  out  1 each  PIC bus strobes
- interrupt_acknowledge_n  out  1  PIC INTA
- address  out  1  A0
- data_bus_out  out  8  write data; data_bus_io_enable  out  1  1 = drive bus
- data_bus_in  in  8  PIC data bus
- vector, call_opcode  out  8, 8  captured INTA bytes; vector_valid  out  1  one-cycle strobe
- busy  out  1  sequencer not IDLE; init_done  out  1  one-cycle pulse after last ICW

## Operation
- Reset values: all _n strobes 1, address 0, data_bus_out 0, data_bus_io_enable 0, busy 0, all done/valid/ack strobes 0, vector/call_opcode/rd_data 0, init pending 0.
- Arbitration in IDLE, fixed priority: init pending > INTA > cmd_req > rd_req. init_start while busy is latched and serviced at next IDLE; cmd_req/rd_req are held by the host until cmd_ack/rd_valid.
- Bus-cycle FSM: IDLE -> SETUP (1 clk: CS_n=0, A0 and data valid, io_enable per direction) -> STROBE (STROBE_CYCLES clks: WR_n or RD_n = 0) -> HOLD (1 clk: strobe 1, CS_n 0, data held) -> GAP (GAP_CYCLES clks, all strobes 1, io_enable 0) -> next step or IDLE.
- Init: ICW1 at A0=0 with bit4 forced 1; ICW2 at A0=1; ICW3 at A0=1 only if icw1[1]=0; ICW4 at A0=1 only if icw1[0]=1. init_done pulses in the GAP exit cycle of the last word.
- INTA: starts when interrupt_to_cpu=1 and int_enable=1 in IDLE. CS_n stays 1; pulses are STROBE_CYCLES low, GAP_CYCLES high. 8086: byte on pulse 2 -> vector. MCS-80: pulse 1 -> call_opcode, pulse 2 -> vector, pulse 3 discarded. vector_valid pulses after the final pulse's GAP. Following a sequence, INT is not re-evaluated until one further IDLE cycle.
- Read data and INTA bytes are sampled from data_bus_in on the clock edge ending the last STROBE cycle.

## Timing
- Write or read: STROBE_CYCLES+2+GAP_CYCLES clocks from grant to ack/valid (defaults: 5).
- INTA: N×(STROBE_CYCLES+GAP_CYCLES) clocks, N=2 or 3.
- Full init (4 words, defaults): 20 clocks from init_start to init_done.
- reset_n low mid-operation: strobes deassert immediately (async), pending requests discarded.
- data_bus_io_enable is 1 only in SETUP/STROBE/HOLD of writes; never during reads or INTA.

## Configuration
- PIC_HOST_MCS80_EN: defined -> mcs80_mode selects the 3-pulse sequence and call_opcode capture. Undefined -> mcs80_mode ignored, always 2 pulses, call_opcode constant 0.

## Test plan
- init_start with icw1=0x11, icw2=0x20, icw3=0x04, icw4=0x01 -> four writes A0=0,1,1,1, data 0x11,0x20,0x04,0x01; init_done after 20 clocks.
- icw1=0x12 (single, no ICW4) -> only ICW1, ICW2 written; ICW3/ICW4 never on bus.
- interrupt_to_cpu=1, PIC returns 0x08 on 2nd INTA, mcs80_mode=0 -> two INTA pulses, CS_n=1 throughout, vector=0x08, vector_valid once.
- MCS-80 (macro defined), bytes 0xCD,0x44,0x00 -> three pulses, call_opcode=0xCD, vector=0x44.
- cmd_req (A0=1, 0xFB) and rd_req same cycle -> write completes first (cmd_ack), then read, rd_data = data_bus_in value.
- reset_n low during ICW2 STROBE -> write_enable_n=1 and chip_select_n=1 within the same cycle; busy=0 after reset release.
